// File: rtl/calc_sequencer.sv
// RPN keypad calculator: digits build an entry, D pushes it, A/B/C combine the top two
// operands in a one-cycle EXEC state, E latches the answer, F clears everything.
module calc_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tok_valid,
    input  logic [3:0]       tok_data,
    output logic             tok_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             error,
    output logic [1:0]       error_code,
    output logic [3:0]       depth,
    output logic [WIDTH-1:0] entry
);

    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  DepthMax = 4'(DEPTH);

    localparam logic [3:0] TokAdd   = 4'hA;
    localparam logic [3:0] TokSub   = 4'hB;
    localparam logic [3:0] TokMul   = 4'hC;
    localparam logic [3:0] TokEnter = 4'hD;
    localparam logic [3:0] TokEqual = 4'hE;
    localparam logic [3:0] TokClear = 4'hF;

    localparam logic [1:0] ErrNone      = 2'b00;
    localparam logic [1:0] ErrUnderflow = 2'b01;
    localparam logic [1:0] ErrOverflow  = 2'b10;

    typedef enum logic [1:0] {StIdle, StExec, StDone, StErr} state_e;
    typedef enum logic [1:0] {OpAdd, OpSub, OpMul} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             use_entry_q, use_entry_d;
    logic             active_q, active_d;
    logic [3:0]       depth_q, depth_d;
    logic [WIDTH-1:0] entry_q, entry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [1:0]       error_code_q, error_code_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];

    logic [IdxW-1:0]  push_idx, top_idx, below_idx, a_idx;
    logic [WIDTH-1:0] a_val, b_val, alu;
    logic             accept;

    assign push_idx  = IdxW'(depth_q);
    assign top_idx   = IdxW'(depth_q - 4'd1);
    assign below_idx = IdxW'(depth_q - 4'd2);

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        use_entry_d    = use_entry_q;
        active_d       = active_q;
        depth_d        = depth_q;
        entry_d        = entry_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        error_code_d   = error_code_q;
        stack_d        = stack_q;

        // Operand b is either the live entry or the top of stack; a sits just below b.
        a_idx = use_entry_q ? top_idx : below_idx;
        b_val = use_entry_q ? entry_q : stack_q[top_idx];
        a_val = stack_q[a_idx];
        case (op_q)
            OpAdd:   alu = a_val + b_val;
            OpSub:   alu = a_val - b_val;
            default: alu = a_val * b_val;
        endcase

        tok_ready = (state_q != StExec);
        accept    = tok_valid && tok_ready;

        if (accept && tok_data == TokClear) begin
            state_d        = StIdle;
            active_d       = 1'b0;
            depth_d        = '0;
            entry_d        = '0;
            result_d       = '0;
            result_valid_d = 1'b0;
            error_code_d   = ErrNone;
            stack_d        = '{default: '0};
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (tok_data)
                            TokAdd, TokSub, TokMul: begin
                                if (active_q ? (depth_q >= 4'd1) : (depth_q >= 4'd2)) begin
                                    op_d = (tok_data == TokAdd) ? OpAdd :
                                           (tok_data == TokSub) ? OpSub : OpMul;
                                    use_entry_d = active_q;
                                    state_d     = StExec;
                                end else begin
                                    error_code_d = ErrUnderflow;
                                    state_d      = StErr;
                                end
                            end
                            TokEnter: begin
                                if (active_q) begin
                                    if (depth_q == DepthMax) begin
                                        error_code_d = ErrOverflow;
                                        state_d      = StErr;
                                    end else begin
                                        stack_d[push_idx] = entry_q;
                                        depth_d           = depth_q + 4'd1;
                                        entry_d           = '0;
                                        active_d          = 1'b0;
                                    end
                                end
                            end
                            TokEqual: begin
                                if (active_q) begin
                                    result_d       = entry_q;
                                    result_valid_d = 1'b1;
                                    state_d        = StDone;
                                end else if (depth_q == 4'd0) begin
                                    error_code_d = ErrUnderflow;
                                    state_d      = StErr;
                                end else begin
                                    result_d       = stack_q[top_idx];
                                    result_valid_d = 1'b1;
                                    state_d        = StDone;
                                end
                            end
                            default: begin
                                entry_d  = entry_q * WIDTH'(10) + WIDTH'(tok_data);
                                active_d = 1'b1;
                            end
                        endcase
                    end
                end
                StExec: begin
                    stack_d[a_idx] = alu;
                    if (!use_entry_q) depth_d = depth_q - 4'd1;
                    entry_d  = '0;
                    active_d = 1'b0;
                    state_d  = StIdle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            op_q           <= OpAdd;
            use_entry_q    <= 1'b0;
            active_q       <= 1'b0;
            depth_q        <= '0;
            entry_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_code_q   <= ErrNone;
            stack_q        <= '{default: '0};
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            use_entry_q    <= use_entry_d;
            active_q       <= active_d;
            depth_q        <= depth_d;
            entry_q        <= entry_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            error_code_q   <= error_code_d;
            stack_q        <= stack_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = (state_q == StErr);
    assign error_code   = error_code_q;
    assign depth        = depth_q;
    assign entry        = entry_q;

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of operand stack entries.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tok_valid, input, 1 bit: a keypad token is offered.
REQ-006 The block SHALL have port tok_data, input, 4 bits: the token code (0-9 digit, A add, B subtract, C multiply, D enter, E equal, F clear).
REQ-007 The block SHALL have port tok_ready, output, 1 bit: the token is accepted on any cycle where tok_valid and tok_ready are both 1.
REQ-008 The block SHALL have port result, output, WIDTH bits: the evaluation result.
REQ-009 The block SHALL have port result_valid, output, 1 bit: result holds a final value.
REQ-010 The block SHALL have port error, output, 1 bit: evaluation aborted.
REQ-011 The block SHALL have port error_code, output, 2 bits: 01 stack underflow, 10 stack overflow, 00 no error.
REQ-012 The block SHALL have port depth, output, 4 bits: the number of occupied stack entries.
REQ-013 The block SHALL have port entry, output, WIDTH bits: the number currently being typed, for display.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, EXEC, DONE and ERR.
REQ-015 tok_ready SHALL be 1 in IDLE, DONE and ERR, and 0 in EXEC.
REQ-016 Digit d accepted in IDLE SHALL give entry <= entry*10 + d, modulo 2^WIDTH, and set entry_active, visible the next cycle.
REQ-017 D accepted in IDLE with entry_active SHALL push entry, clear entry to 0, and clear entry_active.
REQ-018 D accepted in IDLE without entry_active SHALL have no effect.
REQ-019 D accepted in IDLE with entry_active and depth==DEPTH SHALL go to ERR with error_code 10.
REQ-020 An operator (A/B/C) accepted in IDLE SHALL take operand b = entry if entry_active, otherwise the top of stack.
REQ-021 The operator's operand a SHALL be the next stack entry below b.
REQ-022 The operator SHALL require depth>=1 with entry_active, or depth>=2 without entry_active; otherwise it SHALL go to ERR with error_code 01 and leave the stack unchanged.
REQ-023 An accepted operator with sufficient operands SHALL go to EXEC for exactly one cycle.
REQ-024 In EXEC the block SHALL compute a op b: add, subtract (a-b), or multiply keeping the low WIDTH bits; all arithmetic wraps modulo 2^WIDTH.
REQ-025 At the end of EXEC the result SHALL replace a on the stack.
REQ-026 After EXEC, depth SHALL be unchanged if entry was used as b, otherwise decremented by 1.
REQ-027 After EXEC, entry SHALL be 0 and entry_active 0, and the state SHALL return to IDLE.
REQ-028 E accepted in IDLE SHALL latch result = entry if entry_active, otherwise the top of stack, set result_valid and go to DONE.
REQ-029 E accepted in IDLE with no entry_active and depth==0 SHALL go to ERR with error_code 01.
REQ-030 In DONE and ERR, result, result_valid, error and error_code SHALL hold their values; tokens other than F SHALL be accepted and discarded.
REQ-031 F accepted in any state where tok_ready=1 SHALL clear the stack, depth, entry, entry_active, result, result_valid, error and error_code, and go to IDLE on the next cycle.
REQ-032 error SHALL be 1 exactly when the state is ERR.
REQ-033 A token offered during EXEC SHALL remain unaccepted until IDLE; the block SHALL impose no limit on how long the source holds tok_valid.
REQ-034 Stack entry contents SHALL be observable only through result.

Reset
REQ-035 Asserting reset SHALL immediately force state IDLE, depth 0, entry 0, entry_active 0, result 0, result_valid 0, error 0, error_code 00 and tok_ready 1.
REQ-036 Asserting reset during EXEC SHALL abandon the operation with no stack write.
REQ-037 Operation SHALL resume on the first rising clk edge after reset deasserts.

Verification
REQ-038 Tokens 1,2,D,3,4,A,E SHALL produce result=46 with result_valid=1 and depth=1.
REQ-039 Tokens 3,D,5,B,E SHALL produce result=0xFFFFFFFE; tokens 7,D,6,C,E SHALL produce result=42.
REQ-040 Nine repetitions of 1,D SHALL produce ERR on the ninth D with error_code 10 and depth=8; a following F SHALL produce depth=0 and error=0.
REQ-041 Token A with an empty stack and no entry SHALL produce ERR with error_code 01 and depth 0; token E with an empty stack SHALL produce the same.
REQ-042 Tokens 5,D,2 followed by A held on tok_valid SHALL give tok_ready=0 for one cycle (EXEC) and a next token accepted only after return to IDLE; reset asserted in EXEC SHALL give depth=0 and result_valid=0 immediately.
REQ-043 Ten digit tokens 9 SHALL give entry=9999999999 mod 2^32 = 0x540BE3FF with no error.
